// File: rtl/setup_initiator.sv
`default_nettype none
// ============================================================================
// Module      : setup_initiator
// Description : Issues a control-transfer setup packet to an endpoint and
//               tracks the ACK / data phases with a per-phase timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module setup_initiator #(
  parameter logic [7:0] TIMEOUT = 8'd64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  bmRequestType,
  input  logic [7:0]  bRequest,
  input  logic [15:0] wValue,
  input  logic [15:0] wIndex,
  input  logic [15:0] wLength,
  input  logic        ep_busy,
  input  logic [31:0] ep_data_in,
  output logic [63:0] setup_data,
  output logic        ep_enable,
  output logic [31:0] rx_data,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_XFER     = 3'd3,
    ST_FINISH   = 3'd4,
    ST_FAIL     = 3'd5
  } state_t;

  localparam logic [7:0] c_count_last = TIMEOUT - 8'd1;

  state_t      r_state;
  logic [7:0]  r_count;
  logic [63:0] r_setup_data;
  logic [31:0] r_rx_data;
  logic        r_ep_enable;
  logic        r_busy;
  logic        r_done;
  logic        r_error;

  // IN direction with a non-empty data stage is the only case that captures data
  logic w_capture;
  assign w_capture = r_setup_data[63] && (r_setup_data[15:0] != 16'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_count      <= 8'd0;
      r_setup_data <= 64'd0;
      r_rx_data    <= 32'd0;
      r_ep_enable  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_setup_data <= {bmRequestType, bRequest, wValue, wIndex, wLength};
            r_state      <= ST_SETUP;
            r_busy       <= 1'b1;
            r_ep_enable  <= 1'b1;
            r_count      <= 8'd0;
          end
        end
        ST_SETUP: begin
          r_count <= 8'd0;
          r_state <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (ep_busy) begin
            r_state     <= ST_XFER;
            r_ep_enable <= 1'b0;
            r_count     <= 8'd0;
          end else if (r_count == c_count_last) begin
            r_state     <= ST_FAIL;
            r_ep_enable <= 1'b0;
            r_done      <= 1'b1;
            r_error     <= 1'b1;
          end else begin
            r_count <= r_count + 8'd1;
          end
        end
        ST_XFER: begin
          if (!ep_busy) begin
            r_state <= ST_FINISH;
            r_done  <= 1'b1;
            if (w_capture) r_rx_data <= ep_data_in;
          end else if (r_count == c_count_last) begin
            r_state <= ST_FAIL;
            r_done  <= 1'b1;
            r_error <= 1'b1;
          end else begin
            r_count <= r_count + 8'd1;
          end
        end
        ST_FINISH, ST_FAIL: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
          r_ep_enable <= 1'b0;
        end
      endcase
    end
  end

  assign setup_data = r_setup_data;
  assign rx_data    = r_rx_data;
  assign ep_enable  = r_ep_enable;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_setup_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_setup_initiator
// Description : Randomized scoreboard bench for setup_initiator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_setup_initiator;

  localparam logic [7:0] TO = 8'd8;
  localparam int TOI = 8;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  bmRequestType;
  logic [7:0]  bRequest;
  logic [15:0] wValue;
  logic [15:0] wIndex;
  logic [15:0] wLength;
  logic        ep_busy;
  logic [31:0] ep_data_in;
  logic [63:0] setup_data;
  logic        ep_enable;
  logic [31:0] rx_data;
  logic        busy;
  logic        done;
  logic        error;

  setup_initiator #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start),
    .bmRequestType(bmRequestType), .bRequest(bRequest),
    .wValue(wValue), .wIndex(wIndex), .wLength(wLength),
    .ep_busy(ep_busy), .ep_data_in(ep_data_in),
    .setup_data(setup_data), .ep_enable(ep_enable), .rx_data(rx_data),
    .busy(busy), .done(done), .error(error)
  );

  typedef struct {
    int          edge_no;
    logic [63:0] sd;
    logic [31:0] rx;
    logic        err;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [31:0] model_rx = 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest queued expectation.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 expected=0 (t=%0t)", $time);
      end else begin
        e = q.pop_front();
        chk("done_edge", cyc, e.edge_no);
        chk("sb_setup_data", setup_data, e.sd);
        chk("sb_rx_data", rx_data, e.rx);
        chk("sb_error", error, e.err);
      end
    end else if (error === 1'b1) begin
      checks++;
      failures++;
      $display("FAIL error_without_done actual=1 expected=0 (t=%0t)", $time);
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_setup_data"}, setup_data, 64'd0);
    chk({tag, "_rx_data"}, rx_data, 32'd0);
    chk({tag, "_ep_enable"}, ep_enable, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_error"}, error, 1'b0);
  endtask

  // d: WAIT_ACK cycles before the endpoint raises ep_busy (>=TOI: never)
  // b: XFER cycles the endpoint stays busy (>=TOI: stuck)
  task automatic run_xfer(input logic [7:0] rt, input logic [7:0] rq,
                          input logic [15:0] v, input logic [15:0] i, input logic [15:0] l,
                          input logic [31:0] data, input int d, input int b,
                          input bit pre, input bit spurious);
    int   endk;
    int   en;
    logic to;
    exp_t e;
    if (d >= TOI) begin
      endk = TOI + 1;
      to = 1'b1;
    end else if (b >= TOI) begin
      endk = 2 + d + TOI;
      to = 1'b1;
    end else begin
      endk = 3 + d + b;
      to = 1'b0;
    end
    @(negedge clk);
    bmRequestType = rt; bRequest = rq; wValue = v; wIndex = i; wLength = l;
    start = 1'b1;
    ep_busy = pre && (d == 0);
    @(posedge clk);
    #1;
    en = cyc;
    if (!to && rt[7] && (l != 16'd0)) model_rx = data;
    e.edge_no = en + endk;
    e.sd = {rt, rq, v, i, l};
    e.rx = model_rx;
    e.err = to;
    q.push_back(e);
    for (int k = 0; k <= endk + 1; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (spurious && (k == 2 + d || k == endk)) begin
        start = 1'b1;
        wIndex = 16'h0001;
      end
      if (d >= TOI) ep_busy = 1'b0;
      else ep_busy = (pre && d == 0 && k == 0) || (k >= 1 + d && k < 2 + d + b);
      ep_data_in = (k == 2 + d + b) ? data : $urandom();
      chk("ep_enable", ep_enable, (d >= TOI) ? (k <= TOI) : (k <= 1 + d));
      chk("busy", busy, k <= endk);
      chk("done_pulse", done, k == endk);
      chk("error_pulse", error, to && (k == endk));
    end
    start = 1'b0;
    ep_busy = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; bmRequestType = 8'h0; bRequest = 8'h0;
    wValue = 16'h0; wIndex = 16'h0; wLength = 16'h0; ep_busy = 1'b0; ep_data_in = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");

    // reset wins over a simultaneous start
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    bmRequestType = 8'hC0; bRequest = 8'h06; wValue = 16'h1234; wIndex = 16'h5678; wLength = 16'h9ABC;
    @(negedge clk);
    check_all_zero("rst_vs_start");
    rst = 1'b0; start = 1'b0;
    @(negedge clk);

    // OUT transfer leaves rx_data at reset value
    run_xfer(8'h21, 8'h05, 16'h0, 16'h0, 16'h2, 32'hFFFF, 1, 1, 1'b0, 1'b0);
    chk("out_setup_data", setup_data, 64'h2105_0000_0000_0002);
    chk("out_rx_data", rx_data, 32'h0);

    // IN transfer, endpoint busy 3 cycles
    run_xfer(8'hA1, 8'h85, 16'h0, 16'h0, 16'h2, 32'h7, 0, 2, 1'b0, 1'b0);
    chk("in_setup_data", setup_data, 64'hA185_0000_0000_0002);
    chk("in_rx_data", rx_data, 32'h7);

    // no ACK -> WAIT_ACK timeout
    run_xfer(8'hA1, 8'h85, 16'h1, 16'h2, 16'h4, 32'hDEAD, TOI, 0, 1'b0, 1'b0);
    chk("ack_to_rx_data", rx_data, 32'h7);

    // ep_busy already high at SETUP, then stuck in XFER
    run_xfer(8'h80, 8'h06, 16'h3, 16'h0, 16'h8, 32'hBEEF, 0, TOI, 1'b1, 1'b0);
    // ACK exactly at the last WAIT_ACK cycle; XFER ends on its last cycle
    run_xfer(8'hC0, 8'h01, 16'h7, 16'h0, 16'h1, 32'h1111_2222, TOI - 1, TOI - 1, 1'b0, 1'b0);
    // IN with zero length keeps rx_data
    run_xfer(8'h80, 8'h00, 16'h0, 16'h0, 16'h0, 32'h5555, 2, 0, 1'b0, 1'b0);

    // start during XFER and FINISH is ignored
    run_xfer(8'h00, 8'h09, 16'h1, 16'h0, 16'h0, 32'h0, 1, 3, 1'b0, 1'b1);
    chk("spurious_wIndex", setup_data[31:16], 16'h0000);

    // reset while in WAIT_ACK
    @(negedge clk);
    bmRequestType = 8'hA1; bRequest = 8'h85; wValue = 16'h0; wIndex = 16'h0; wLength = 16'h2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("wait_ack_en_before_rst", ep_enable, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid_rst");
    rst = 1'b0;
    model_rx = 32'd0;
    run_xfer(8'hA1, 8'h85, 16'h0, 16'h0, 16'h2, 32'h7, 0, 2, 1'b0, 1'b0);
    chk("post_rst_rx_data", rx_data, 32'h7);

    for (int n = 0; n < 14; n++) begin
      logic [7:0] rt;
      logic [15:0] len;
      rt = 8'($urandom());
      len = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom());
      run_xfer(rt, 8'($urandom()), 16'($urandom()), 16'($urandom()), len, $urandom(),
               int'($urandom_range(0, TOI + 1)), int'($urandom_range(0, TOI + 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/setup_initiator.md
SETUP_INITIATOR -- requirements
Module: setup_initiator

Interface
REQ-001 Parameter TIMEOUT, default 8'd64, max cycles to wait per handshake phase (legal 1..255).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  one-cycle request to issue a control transfer.
REQ-005 bmRequestType  input  8  request type; bit 7 = 1 means IN (device-to-host).
REQ-006 bRequest  input  8  request code (e.g. 8'h05 SET, 8'h85 GET).
REQ-007 wValue, wIndex, wLength  input  16 each  setup fields.
REQ-008 ep_busy  input  1  busy flag from the control endpoint.
REQ-009 ep_data_in  input  32  endpoint response word (32-bit data_out).
REQ-010 setup_data  output  64  packed setup packet to endpoint.
REQ-011 ep_enable  output  1  request strobe to endpoint.
REQ-012 rx_data  output  32  captured IN response.
REQ-013 busy  output  1  transfer in progress.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 error  output  1  one-cycle timeout pulse, coincident with done.

Function
REQ-016 Packing SHALL be exact, no overlap: [63:56] bmRequestType, [55:48] bRequest, [47:32] wValue, [31:16] wIndex, [15:0] wLength.
REQ-017 setup_data SHALL be registered on start acceptance and held stable until next accepted start.
REQ-018 FSM states: IDLE, SETUP, WAIT_ACK, XFER, FINISH, FAIL.
REQ-019 IDLE: start=1 -> SETUP next edge; fields latched same edge; busy=1 from that edge.
REQ-020 start while busy=1 SHALL be ignored (no re-latch, no restart).
REQ-021 SETUP: exactly one cycle; ep_enable=1; timeout counter cleared; -> WAIT_ACK.
REQ-022 WAIT_ACK: ep_enable held 1; ep_busy=1 -> XFER with ep_enable=0 next edge; else counter+1.
REQ-023 XFER: ep_enable=0; on first cycle ep_busy=0 -> FINISH; if bmRequestType[7]=1 and wLength!=0, rx_data <= ep_data_in on that edge.
REQ-024 OUT transfers (bit 7=0) or wLength=0 SHALL leave rx_data unchanged.
REQ-025 Counter 8-bit, cleared on every phase entry (WAIT_ACK, XFER); counter reaching TIMEOUT-1 in WAIT_ACK or XFER without exit condition -> FAIL.
REQ-026 Exit condition and timeout in same cycle: exit condition wins.
REQ-027 FINISH: done=1, error=0, one cycle -> IDLE; busy=0 from following edge.
REQ-028 FAIL: done=1, error=1, ep_enable=0, one cycle -> IDLE; rx_data unchanged.
REQ-029 start asserted in FINISH/FAIL cycle SHALL be ignored; accepted earliest in IDLE.
REQ-030 Latency, responsive endpoint: start edge N -> ep_enable high N+1.. ; done = 2 cycles after ep_busy falls is NOT allowed -- done SHALL be the cycle after the XFER exit edge.
REQ-031 ep_busy already high on SETUP entry SHALL be accepted in first WAIT_ACK cycle (no edge required).

Reset
REQ-032 rst=1 at an edge: state IDLE, setup_data=0, rx_data=0, counter=0, ep_enable=0, busy=0, done=0, error=0.
REQ-033 rst mid-transfer SHALL abort without done/error pulse; ep_enable low by the same edge.
REQ-034 rst dominates start in the same cycle.

Verification
REQ-035 IN: start, fields 8'hA1/8'h85/0/0/2, endpoint busy 3 cycles, ep_data_in=32'h7 -> setup_data=64'hA185_0000_0000_0002, rx_data=32'h7, done=1 error=0.
REQ-036 OUT: 8'h21/8'h05/0/0/2, ep_data_in=32'hFFFF -> setup_data=64'h2105_0000_0000_0002, rx_data unchanged (0 after reset), done=1.
REQ-037 Timeout: TIMEOUT=8, ep_busy tied 0 -> FAIL after 8 WAIT_ACK cycles, done=error=1 one cycle, ep_enable=0 after.
REQ-038 Busy stuck: ep_busy tied 1 -> ACK, then XFER timeout after TIMEOUT cycles, error=1.
REQ-039 start pulsed during XFER with wIndex=1 -> ignored; setup_data keeps wIndex=0; single done.
REQ-040 rst asserted in WAIT_ACK -> all outputs zero next edge, no done; fresh start then completes normally.
